ide_spi_frontend: RTL
=====================

// Module: ide_spi_frontend
// PURPOSE
// - Clk-domain SPI slave front-end between the MCU SPI pins and the IDE taskfile/sector buffer.
// - Oversamples ss1_n/ss2_n/sclk/mosi and decodes SPI mode 0, MSB first.
// - ss1_n: shifts out a 64-bit status snapshot.
// - ss2_n: receives one header byte, then 16-bit words with an index; shifts out 16-bit sector words on request.
// - Removes the sclk-clocked logic from the taskfile; the taskfile consumes clean single-clk strobes.
// PARAMETERS
// - SYNC_STAGES  2   synchroniser flops per pin, minimum 2
// - STAT_W       64  status snapshot width
// PORTS
// - clk          in   1   system clock; f_clk >= 8 x f_sclk
// - reset        in   1   asynchronous, active-high
// - spi_ss1_n    in   1   status channel select, active low
// - spi_ss2_n    in   1   data channel select, active low
// - spi_sclk     in   1   SPI clock, idle low
// - spi_mosi     in   1   MCU -> FPGA data
// - spi_miso     out  1   FPGA -> MCU data
// - spi_miso_oe  out  1   tristate enable for spi_miso
// - status_in    in   64  status snapshot source
// - tx_word      in   16  next outbound data word
// - tx_req       out  1   1-clk pulse: tx_word consumed, present the next word
// - hdr_byte     out  8   header byte of the current ss2 frame
// - hdr_valid    out  1   1-clk pulse: hdr_byte updated
// - rx_word      out  16  received word, first bit received in [15]
// - rx_idx       out  9   index of rx_word in the frame; 0 = first word after the header
// - rx_valid     out  1   1-clk pulse: rx_word/rx_idx updated
// - frame_end    out  1   1-clk pulse: ss2 frame closed
// - frame_abort  out  1   valid with frame_end: frame closed mid-byte or mid-word
// BEHAVIOUR
// - Reset values: all outputs 0; shift registers, counters and state cleared; state IDLE.
// - Sync: every pin passes SYNC_STAGES flops plus 1 edge-detect flop; pin edge -> internal pulse in 3 clk.
// - Arming: after reset, or after the ignored channel's frame, a frame starts only on a synced high->low ss edge.
// - FSM IDLE -> STAT | HDR; HDR -> DATA; STAT | HDR | DATA -> IDLE when the owning ss goes high.
// - Select priority: ss1 falling edge in IDLE wins when both fall together.
// - Foreign select: the other channel's ss is ignored until it deasserts.
// - STAT: status_in captured on ss1 entry. MISO = msb; shift left on each sclk fall. Past 64 bits, 0 shifts out.
// - HDR: mosi sampled on sclk rise; after 8 bits, hdr_byte loads and hdr_valid pulses same clk. Enter DATA, rx_idx = 0.
// - DATA rx: after 16 sampled bits, rx_word loads and rx_valid pulses with rx_idx. rx_idx then increments, 511 -> 0.
// - DATA tx: tx shifter loads tx_word on entry to HDR; the header byte shifts out its top 8 bits.
// - DATA tx reload: on the sclk rise completing each 16-bit word in DATA, tx_req pulses.
// - tx_word is sampled exactly 1 clk after tx_req and loads the shifter before the next sclk fall.
// - Bit counters are independent of the FSM: header 0..7, word 0..15.
// - Simultaneous events: sclk rise and owning-ss rise in the same clk -> ss wins; the bit is dropped.
// - Close: frame_end pulses on ss2 close. frame_abort = 1 if the bit counter != 0.
// - Partial byte/word: discarded, never emitted.
// - ss1 close emits nothing.
// - spi_miso_oe = 1 while in STAT or HDR/DATA; spi_miso = 0 whenever spi_miso_oe = 0.
// - Reset mid-frame: everything clears immediately. No pulses until ss high is seen and a new edge arrives.
// STRUCTURE
// - Shared package ide_pkg: FSM state enum, STAT_W, header bit positions (HDR_SECTOR_WR = 7, HDR_CMD_WR = 6).
// - Sub-module spi_pin_sync: SYNC_STAGES synchroniser + rise/fall pulses.
// - spi_pin_sync is instantiated once per pin; the FSM and shifters are inline.
// TESTING
// - ss2 low, send 0x80 then 0x1234, 0xABCD, ss2 high.
//   -> hdr_valid with 0x80; rx_valid 0x1234/idx 0 and 0xABCD/idx 1; frame_end=1, frame_abort=0.
// - ss1 frame, status_in = 64'hDEAD_BEEF_0123_4567, 64 clocks -> MISO stream equals the value MSB first.
// - ss1 frame, status_in changes mid-frame -> MISO stream still equals the captured value.
// - ss2 frame, tx_word answers each tx_req with 0x0001, 0x0002, 0x0003.
//   -> MISO after the header carries those words in order, 1 clk tx_req -> load.
// - ss2 released after header + 5 bits -> frame_end=1, frame_abort=1, no rx_valid.
// - Next frame decodes cleanly after the aborted one.
// - ss1 and ss2 fall in the same clk -> STAT entered, no hdr_valid.
// - Reset asserted mid-word with ss2 held low -> outputs 0, no pulses until ss2 toggles high -> low.
// - 512 words in one frame -> rx_idx wraps 511 -> 0, no dropped rx_valid.
// - Run at f_clk = 8 x f_sclk.

Source files
------------

// File: rtl/ide_pkg.sv
// Shared types and constants for the IDE SPI front-end (FSM states, widths, header bits).
// Latency: none, definitions only.
// Backpressure: none, definitions only.
package ide_pkg;

  localparam int STAT_W = 64;

  // Header byte flag positions, decoded by the taskfile.
  localparam int HDR_SECTOR_WR = 7;
  localparam int HDR_CMD_WR    = 6;

  // Last bit index of a header byte and of a data word.
  localparam logic [3:0] HDR_LAST  = 4'd7;
  localparam logic [3:0] WORD_LAST = 4'd15;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_STAT = 2'd1,
    ST_HDR  = 2'd2,
    ST_DATA = 2'd3
  } spi_state_t;

endpackage

// File: rtl/spi_pin_sync.sv
// Synchronises one SPI pin into clk and produces single-clk rise/fall pulses.
// Latency: pin edge -> pulse visible after SYNC_STAGES clk, acted on at the following edge.
// Backpressure: none; pulses are free-running and must be consumed when they occur.
module spi_pin_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic pin,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   last_q;

  // Synchroniser chain plus one flop holding the previous synced level.
  // Clearing to 0 means a pin held low through reset never produces a fall.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
      last_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pin};
      last_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level = sync_q[SYNC_STAGES-1];
  assign rise  = level & ~last_q;
  assign fall  = ~level & last_q;

endmodule

// File: rtl/ide_spi_frontend.sv
// SPI mode-0 slave front-end: status snapshot on ss1, header/word exchange on ss2, clean clk strobes out.
// Latency: pin edge -> action 3 clk; rx/hdr strobes 1 clk after the synced sclk rise completing the unit.
// Backpressure: none; tx_word must be valid 1 clk after tx_req, strobes are not held.
module ide_spi_frontend #(
  parameter int SYNC_STAGES = 2,
  parameter int STAT_W      = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              spi_ss1_n,
  input  logic              spi_ss2_n,
  input  logic              spi_sclk,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic              spi_miso_oe,
  input  logic [STAT_W-1:0] status_in,
  input  logic [15:0]       tx_word,
  output logic              tx_req,
  output logic [7:0]        hdr_byte,
  output logic              hdr_valid,
  output logic [15:0]       rx_word,
  output logic [8:0]        rx_idx,
  output logic              rx_valid,
  output logic              frame_end,
  output logic              frame_abort
);

  import ide_pkg::*;

  logic ss1_lvl, ss1_rise, ss1_fall;
  logic ss2_lvl, ss2_rise, ss2_fall;
  logic sclk_lvl, sclk_rise, sclk_fall;
  logic mosi_lvl, mosi_rise, mosi_fall;

  spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ss1 (
    .clk(clk), .reset(reset), .pin(spi_ss1_n), .level(ss1_lvl), .rise(ss1_rise), .fall(ss1_fall));
  spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ss2 (
    .clk(clk), .reset(reset), .pin(spi_ss2_n), .level(ss2_lvl), .rise(ss2_rise), .fall(ss2_fall));
  spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
    .clk(clk), .reset(reset), .pin(spi_sclk), .level(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall));
  spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_mosi (
    .clk(clk), .reset(reset), .pin(spi_mosi), .level(mosi_lvl), .rise(mosi_rise), .fall(mosi_fall));

  // Only edges matter for the selects and sclk; only the level matters for mosi.
  logic unused_pins;
  assign unused_pins = ^{ss1_lvl, ss2_lvl, sclk_lvl, mosi_rise, mosi_fall};

  spi_state_t        state_q, state_d;
  logic              enter_stat, enter_hdr, close_dat, take_bit;
  logic              hdr_done, word_done;
  logic [3:0]        bit_cnt_q;
  logic [14:0]       rx_sr_q;
  logic [8:0]        idx_cnt_q;
  logic [STAT_W-1:0] stat_sr_q;
  logic [15:0]       tx_sr_q;
  logic              tx_skip_q;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next state and per-clk frame events; ss1 wins a simultaneous fall, and an owning-ss
  // rise beats an sclk rise in the same clk so that bit is dropped.
  always_comb begin
    state_d    = state_q;
    enter_stat = 1'b0;
    enter_hdr  = 1'b0;
    close_dat  = 1'b0;
    take_bit   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ss1_fall) begin
          state_d    = ST_STAT;
          enter_stat = 1'b1;
        end else if (ss2_fall) begin
          state_d   = ST_HDR;
          enter_hdr = 1'b1;
        end
      end
      ST_STAT: begin
        if (ss1_rise) state_d = ST_IDLE;
      end
      ST_HDR, ST_DATA: begin
        if (ss2_rise) begin
          state_d   = ST_IDLE;
          close_dat = 1'b1;
        end else if (sclk_rise) begin
          take_bit = 1'b1;
          if (state_q == ST_HDR && bit_cnt_q == HDR_LAST) state_d = ST_DATA;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign hdr_done  = take_bit && (state_q == ST_HDR)  && (bit_cnt_q == HDR_LAST);
  assign word_done = take_bit && (state_q == ST_DATA) && (bit_cnt_q == WORD_LAST);

  // Status shifter: snapshot on ss1 entry, shift on sclk fall, zeros fill in behind.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_sr_q <= '0;
    end else if (enter_stat) begin
      stat_sr_q <= status_in;
    end else if (state_q == ST_STAT && sclk_fall) begin
      stat_sr_q <= {stat_sr_q[STAT_W-2:0], 1'b0};
    end
  end

  // Tx shifter: loaded on ss2 entry (its top byte goes out under the header), then
  // reloaded 1 clk after every tx_req. tx_req also fires at the end of the header so
  // the first data word is requested in time. A reload happens after the completing
  // rise, so the following fall must not shift or the new msb would be lost.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_sr_q   <= '0;
      tx_skip_q <= 1'b0;
    end else if (enter_hdr) begin
      tx_sr_q   <= tx_word;
      tx_skip_q <= 1'b0;
    end else if (tx_req) begin
      tx_sr_q   <= tx_word;
      tx_skip_q <= 1'b1;
    end else if ((state_q == ST_HDR || state_q == ST_DATA) && sclk_fall) begin
      if (tx_skip_q) tx_skip_q <= 1'b0;
      else           tx_sr_q   <= {tx_sr_q[14:0], 1'b0};
    end
  end

  // Receive path, bit counting and the taskfile strobes. Partial units are simply
  // never emitted; the counter value at close tells whether the frame was aborted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bit_cnt_q   <= '0;
      rx_sr_q     <= '0;
      idx_cnt_q   <= '0;
      hdr_byte    <= '0;
      hdr_valid   <= 1'b0;
      rx_word     <= '0;
      rx_idx      <= '0;
      rx_valid    <= 1'b0;
      tx_req      <= 1'b0;
      frame_end   <= 1'b0;
      frame_abort <= 1'b0;
    end else begin
      hdr_valid   <= 1'b0;
      rx_valid    <= 1'b0;
      tx_req      <= 1'b0;
      frame_end   <= 1'b0;
      frame_abort <= 1'b0;
      if (enter_hdr) begin
        bit_cnt_q <= '0;
      end else if (take_bit) begin
        rx_sr_q   <= {rx_sr_q[13:0], mosi_lvl};
        bit_cnt_q <= (hdr_done || word_done) ? 4'd0 : bit_cnt_q + 4'd1;
      end
      if (hdr_done) begin
        hdr_byte  <= {rx_sr_q[6:0], mosi_lvl};
        hdr_valid <= 1'b1;
        idx_cnt_q <= '0;
        rx_idx    <= '0;
        tx_req    <= 1'b1;
      end
      if (word_done) begin
        rx_word   <= {rx_sr_q, mosi_lvl};
        rx_idx    <= idx_cnt_q;
        rx_valid  <= 1'b1;
        idx_cnt_q <= idx_cnt_q + 9'd1;
        tx_req    <= 1'b1;
      end
      if (close_dat) begin
        frame_end   <= 1'b1;
        frame_abort <= (bit_cnt_q != 4'd0);
      end
    end
  end

  // MISO mux; driven low whenever the pin is not enabled.
  always_comb begin
    spi_miso = 1'b0;
    case (state_q)
      ST_STAT:         spi_miso = stat_sr_q[STAT_W-1];
      ST_HDR, ST_DATA: spi_miso = tx_sr_q[15];
      default:         spi_miso = 1'b0;
    endcase
  end

  assign spi_miso_oe = (state_q != ST_IDLE);

endmodule
